// File: rtl/ntt_router_seq.sv
// Stage sequencer and butterfly-result router between NTT cores and their coefficient RAMs.
// Routes each accepted beat to loop-back RAM ports or to the output bus with one cycle of latency.
module ntt_router_seq #(
  parameter int LOG_CORE_COUNT = 5,
  parameter int LOG_N          = 12,
  parameter int COEFF_W        = 30,
  parameter int ADDR_W         = 9,
  parameter int STAGE_W        = 4
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   start,
  input  logic                                                   in_valid,
  input  logic [ADDR_W-1:0]                                      address_0,
  input  logic [ADDR_W-1:0]                                      address_1,
  input  logic [(1<<LOG_CORE_COUNT)-1:0][3:0][COEFF_W-1:0]       in,
  output logic [STAGE_W-1:0]                                     stage_log_m,
  output logic [STAGE_W-1:0]                                     stage_log_t,
  output logic                                                   busy,
  output logic                                                   done,
  output logic [(1<<LOG_CORE_COUNT)-1:0][1:0][2*COEFF_W-1:0]     loop,
  output logic [(1<<LOG_CORE_COUNT)-1:0][1:0]                    loop_we,
  output logic [1:0][ADDR_W-1:0]                                 address_loop,
  output logic [(1<<LOG_CORE_COUNT)-1:0][1:0][2*COEFF_W-1:0]     out,
  output logic                                                   out_valid,
  output logic [ADDR_W-1:0]                                      address_out,
  output logic                                                   collision
);

  // state | meaning
  // IDLE  | waiting for start, beats ignored
  // RUN   | stepping through stages, one beat per accepted in_valid
  // DONE  | single cycle after the last OUTPUT beat, done asserted

  localparam int C         = 1 << LOG_CORE_COUNT;
  localparam int BEAT_LOG  = LOG_N - LOG_CORE_COUNT - 2;
  localparam int BEATS     = 1 << BEAT_LOG;
  localparam int BEAT_W    = (BEAT_LOG > 0) ? BEAT_LOG : 1;
  localparam int TH        = LOG_N - (LOG_CORE_COUNT + 2);
  localparam int CI_W      = (LOG_CORE_COUNT > 0) ? LOG_CORE_COUNT : 1;

  localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [STAGE_W-1:0] LT_INIT   = STAGE_W'(LOG_N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [STAGE_W-1:0]   log_m_q, log_m_d;
  logic [STAGE_W-1:0]   log_t_q, log_t_d;
  logic                 accept;

  function automatic logic [CI_W-1:0] ci(input int k);
    return CI_W'(k);
  endfunction

  assign accept      = (state_q == S_RUN) && in_valid;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign stage_log_m = log_m_q;
  assign stage_log_t = log_t_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      log_m_q <= '0;
      log_t_q <= LT_INIT;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      log_m_q <= log_m_d;
      log_t_q <= log_t_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    log_m_d = log_m_q;
    log_t_d = log_t_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          beat_d  = '0;
          log_m_d = '0;
          log_t_d = LT_INIT;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          if (beat_q == BEAT_LAST) begin
            beat_d = '0;
            if (log_t_q == '1) begin
              state_d = S_DONE;
              log_m_d = '0;
              log_t_d = LT_INIT;
            end else begin
              // log_t steps past 0 into all-ones, which selects the OUTPUT stage
              log_m_d = log_m_q + 1'b1;
              log_t_d = log_t_q - 1'b1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic [C-1:0][1:0][2*COEFF_W-1:0] loop_nx, out_nx;
  logic [C-1:0][1:0]                we_nx;
  logic [1:0][ADDR_W-1:0]           aloop_nx;
  logic [ADDR_W-1:0]                aout_nx;
  logic                             ov_nx;
  logic                             coll_nx;
  int                               conv_sh;
  int                               conv_d;
  logic [ADDR_W-1:0]                pair_h;
  logic                             pe, po;
  logic                             lower;

  always_comb begin
    loop_nx  = loop;
    we_nx    = '0;
    aloop_nx = address_loop;
    out_nx   = out;
    aout_nx  = address_out;
    ov_nx    = 1'b0;
    coll_nx  = collision;
    // Lower/upper split tests core-index bit conv_sh; the partner core sits conv_d away
    conv_sh  = LOG_CORE_COUNT - 1 - int'(log_m_q);
    conv_d   = (conv_sh >= 0) ? (1 << conv_sh) : 0;
    pair_h   = ADDR_W'((1 << int'(log_t_q)) >> 1);
    pe       = (address_0 & pair_h) != '0;
    po       = (address_1 & pair_h) != '0;
    lower    = 1'b0;
    if (accept) begin
      if (log_t_q == '1) begin
        for (int k = 0; k < C; k++) begin
          out_nx[ci(k)][0] = {in[ci(k)][1], in[ci(k)][0]};
          out_nx[ci(k)][1] = {in[ci(k)][3], in[ci(k)][2]};
        end
        aout_nx = address_0;
        ov_nx   = 1'b1;
      end else if (int'(log_t_q) > TH) begin
        for (int k = 0; k < C; k++) begin
          lower = 1'b1;
          if (conv_sh >= 0) lower = ((k >> conv_sh) & 1) == 0;
          we_nx[ci(k)] = 2'b11;
          if (lower) begin
            loop_nx[ci(k)][0] = {in[ci(k)][2], in[ci(k)][0]};
            if (k + conv_d < C) loop_nx[ci(k)][1] = {in[ci(k + conv_d)][2], in[ci(k + conv_d)][0]};
            else                loop_nx[ci(k)][1] = '0;
          end else begin
            if (k - conv_d >= 0) loop_nx[ci(k)][0] = {in[ci(k - conv_d)][3], in[ci(k - conv_d)][1]};
            else                 loop_nx[ci(k)][0] = '0;
            loop_nx[ci(k)][1] = {in[ci(k)][3], in[ci(k)][1]};
          end
        end
        aloop_nx[0] = address_0;
        aloop_nx[1] = address_1;
      end else if (log_t_q != '0) begin
        for (int j = 0; j < C / 2; j++) begin
          loop_nx[ci(2*j)][pe]   = {in[ci(2*j)][2], in[ci(2*j)][0]};
          loop_nx[ci(2*j+1)][pe] = {in[ci(2*j)][3], in[ci(2*j)][1]};
          we_nx[ci(2*j)][pe]     = 1'b1;
          we_nx[ci(2*j+1)][pe]   = 1'b1;
          if (pe != po) begin
            loop_nx[ci(2*j)][po]   = {in[ci(2*j+1)][2], in[ci(2*j+1)][0]};
            loop_nx[ci(2*j+1)][po] = {in[ci(2*j+1)][3], in[ci(2*j+1)][1]};
            we_nx[ci(2*j)][po]     = 1'b1;
            we_nx[ci(2*j+1)][po]   = 1'b1;
          end
        end
        // Both halves land on the same row of their port, so each address is folded down by h
        aloop_nx[pe] = address_0 - (pe ? pair_h : '0);
        if (pe != po) aloop_nx[po] = address_1 - (po ? pair_h : '0);
        else          coll_nx      = 1'b1;
      end else begin
        for (int k = 0; k < C; k++) begin
          loop_nx[ci(k)][0] = {in[ci(k)][2], in[ci(k)][0]};
          loop_nx[ci(k)][1] = {in[ci(k)][3], in[ci(k)][1]};
          we_nx[ci(k)]      = 2'b11;
        end
        aloop_nx[0] = address_0;
        aloop_nx[1] = address_1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loop         <= '0;
      loop_we      <= '0;
      address_loop <= '0;
      out          <= '0;
      out_valid    <= 1'b0;
      address_out  <= '0;
      collision    <= 1'b0;
    end else begin
      loop         <= loop_nx;
      loop_we      <= we_nx;
      address_loop <= aloop_nx;
      out          <= out_nx;
      out_valid    <= ov_nx;
      address_out  <= aout_nx;
      collision    <= coll_nx;
    end
  end

endmodule

// File: tb/tb_ntt_router_seq.sv
// Directed bench for ntt_router_seq at default parameters: table of routed beats plus
// hand sequences for reset, OUTPUT gaps, done/busy and mid-transform reset.
module tb_ntt_router_seq;

  logic                        clk;
  logic                        rst;
  logic                        start;
  logic                        in_valid;
  logic [8:0]                  address_0;
  logic [8:0]                  address_1;
  logic [31:0][3:0][29:0]      din;
  logic [3:0]                  stage_log_m;
  logic [3:0]                  stage_log_t;
  logic                        busy;
  logic                        done;
  logic [31:0][1:0][59:0]      loop;
  logic [31:0][1:0]            loop_we;
  logic [1:0][8:0]             address_loop;
  logic [31:0][1:0][59:0]      out;
  logic                        out_valid;
  logic [8:0]                  address_out;
  logic                        collision;

  ntt_router_seq dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .address_0(address_0), .address_1(address_1), .in(din),
    .stage_log_m(stage_log_m), .stage_log_t(stage_log_t), .busy(busy), .done(done),
    .loop(loop), .loop_we(loop_we), .address_loop(address_loop),
    .out(out), .out_valid(out_valid), .address_out(address_out), .collision(collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  int g      = 0;

  typedef struct {
    int         g;
    logic [8:0] a0;
    logic [8:0] a1;
    int         core;
    int         port;
    logic [59:0] data;
    bit         chk_data;
    logic [1:0] we;
    logic [8:0] addr;
    bit         chk_addr;
    logic       coll;
  } vec_t;

  vec_t vec [15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_lt(input int beat);
    int s;
    s = beat / 32;
    return (s >= 12) ? 64'd15 : 64'(11 - s);
  endfunction

  task automatic send(input logic [8:0] x0, input logic [8:0] x1);
    @(negedge clk);
    in_valid  = 1'b1;
    address_0 = x0;
    address_1 = x1;
    if (g % 32 == 0) begin
      chk($sformatf("stage_log_t@%0d", g), 64'(stage_log_t), exp_lt(g));
      chk($sformatf("stage_log_m@%0d", g), 64'(stage_log_m), 64'(g / 32));
    end
    @(posedge clk);
    #1;
    g++;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g     = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [4:0] ck;
    logic       pp;

    for (int k = 0; k < 32; k++)
      for (int i = 0; i < 4; i++)
        din[5'(k)][2'(i)] = 30'(k * 4 + i);

    //                g    a0      a1      core port data                  cd we     addr    ca coll
    vec[0]  = '{  0, 9'd5,   9'd9,   0,  1, {30'd66,  30'd64},  1, 2'b11, 9'd9,   1, 1'b0};
    vec[1]  = '{  1, 9'd5,   9'd9,  16,  0, {30'd3,   30'd1},   1, 2'b11, 9'd5,   1, 1'b0};
    vec[2]  = '{  2, 9'd17,  9'd33,  5,  0, {30'd22,  30'd20},  1, 2'b11, 9'd17,  1, 1'b0};
    vec[3]  = '{  3, 9'd17,  9'd33, 20,  1, {30'd83,  30'd81},  1, 2'b11, 9'd33,  1, 1'b0};
    vec[4]  = '{ 32, 9'd7,   9'd8,   3,  0, {30'd14,  30'd12},  1, 2'b11, 9'd7,   1, 1'b0};
    vec[5]  = '{288, 9'd1,   9'd3,   4,  0, {30'd18,  30'd16},  1, 2'b11, 9'd1,   1, 1'b0};
    vec[6]  = '{289, 9'd1,   9'd3,   5,  1, {30'd23,  30'd21},  1, 2'b11, 9'd1,   1, 1'b0};
    vec[7]  = '{290, 9'd1,   9'd3,   5,  0, {30'd19,  30'd17},  1, 2'b11, 9'd1,   1, 1'b0};
    vec[8]  = '{291, 9'd2,   9'd0,   6,  1, {30'd26,  30'd24},  1, 2'b11, 9'd0,   1, 1'b0};
    vec[9]  = '{292, 9'd2,   9'd0,   7,  0, {30'd31,  30'd29},  1, 2'b11, 9'd0,   0, 1'b0};
    vec[10] = '{293, 9'd0,   9'd0,   2,  0, {30'd10,  30'd8},   1, 2'b01, 9'd0,   1, 1'b1};
    vec[11] = '{294, 9'd0,   9'd0,   3,  0, {30'd11,  30'd9},   1, 2'b01, 9'd0,   0, 1'b1};
    vec[12] = '{320, 9'd3,   9'd4,   0,  1, {30'd2,   30'd0},   1, 2'b11, 9'd2,   1, 1'b1};
    vec[13] = '{352, 9'd100, 9'd200,31,  1, {30'd127, 30'd125}, 1, 2'b11, 9'd200, 1, 1'b1};
    vec[14] = '{353, 9'd100, 9'd200,31,  0, {30'd126, 30'd124}, 1, 2'b11, 9'd100, 1, 1'b1};

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; address_0 = '0; address_1 = '0;
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy",        64'(busy), 64'd0);
    chk("rst done",        64'(done), 64'd0);
    chk("rst out_valid",   64'(out_valid), 64'd0);
    chk("rst loop_we",     64'(loop_we), 64'd0);
    chk("rst collision",   64'(collision), 64'd0);
    chk("rst stage_log_t", 64'(stage_log_t), 64'd11);
    chk("rst stage_log_m", 64'(stage_log_m), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // beat offered while idle must not write anything
    @(negedge clk);
    in_valid = 1'b1; address_0 = 9'd3; address_1 = 9'd4;
    @(posedge clk);
    #1;
    chk("idle loop_we",   64'(loop_we), 64'd0);
    chk("idle out_valid", 64'(out_valid), 64'd0);
    chk("idle busy",      64'(busy), 64'd0);

    start_pulse();
    chk("start busy", 64'(busy), 64'd1);

    for (int v = 0; v < 15; v++) begin
      while (g < vec[v].g) begin
        if (g == 100) start = 1'b1;
        send(9'd0, 9'h1FF);
        start = 1'b0;
      end
      send(vec[v].a0, vec[v].a1);
      ck = 5'(vec[v].core);
      pp = vec[v].port[0];
      if (vec[v].chk_data) chk($sformatf("v%0d loop data", v), 64'(loop[ck][pp]), 64'(vec[v].data));
      chk($sformatf("v%0d loop_we", v), 64'(loop_we[ck]), 64'(vec[v].we));
      if (vec[v].chk_addr) chk($sformatf("v%0d address_loop", v), 64'(address_loop[pp]), 64'(vec[v].addr));
      chk($sformatf("v%0d collision", v), 64'(collision), 64'(vec[v].coll));
      chk($sformatf("v%0d out_valid", v), 64'(out_valid), 64'd0);
    end

    while (g < 384) send(9'd0, 9'h1FF);
    chk("pre-output out_valid", 64'(out_valid), 64'd0);

    send(9'h01A, 9'h055);
    chk("out1 out_valid",   64'(out_valid), 64'd1);
    chk("out1 address_out", 64'(address_out), 64'h01A);
    chk("out1 core3 p0",    64'(out[3][0]), 64'({30'd13, 30'd12}));
    chk("out1 core3 p1",    64'(out[3][1]), 64'({30'd15, 30'd14}));
    chk("out1 core31 p1",   64'(out[31][1]), 64'({30'd127, 30'd126}));
    chk("out1 loop_we",     64'(loop_we), 64'd0);
    idle_cycle();
    chk("gap out_valid",    64'(out_valid), 64'd0);
    chk("gap address_out",  64'(address_out), 64'h01A);
    chk("gap core3 p0",     64'(out[3][0]), 64'({30'd13, 30'd12}));
    send(9'h0C7, 9'h000);
    chk("out2 out_valid",   64'(out_valid), 64'd1);
    chk("out2 address_out", 64'(address_out), 64'h0C7);
    chk("out2 loop_we",     64'(loop_we), 64'd0);

    while (g < 415) send(9'd0, 9'h1FF);
    chk("pre-last done", 64'(done), 64'd0);
    send(9'd0, 9'h1FF);
    chk("last done",      64'(done), 64'd1);
    chk("last busy",      64'(busy), 64'd1);
    chk("last out_valid", 64'(out_valid), 64'd1);
    idle_cycle();
    chk("after done",        64'(done), 64'd0);
    chk("after busy",        64'(busy), 64'd0);
    chk("after stage_log_t", 64'(stage_log_t), 64'd11);
    chk("after stage_log_m", 64'(stage_log_m), 64'd0);
    chk("sticky collision",  64'(collision), 64'd1);

    // asynchronous reset at beat 7 of stage 3
    start_pulse();
    while (g < 103) send(9'd0, 9'h1FF);
    chk("pre-reset loop_we", 64'(loop_we), 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midrst busy",        64'(busy), 64'd0);
    chk("midrst loop_we",     64'(loop_we), 64'd0);
    chk("midrst out_valid",   64'(out_valid), 64'd0);
    chk("midrst collision",   64'(collision), 64'd0);
    chk("midrst stage_log_t", 64'(stage_log_t), 64'd11);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    start_pulse();
    send(9'd5, 9'd9);
    chk("restart core0 p1", 64'(loop[0][1]), 64'({30'd66, 30'd64}));
    chk("restart addr1",    64'(address_loop[1]), 64'd9);
    idle_cycle();
    chk("restart idle we",  64'(loop_we), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
